// File: rtl/prog_loader.sv
// Byte-stream program loader: decodes framed bytes from the host receiver and
// drives the instruction/data memory write ports of the core, holding the core
// in reset while a program is being loaded.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a command byte (IMEM / DMEM / RUN)
// ADDR   | next byte is the start address
// LEN    | next byte is the word count (0 = 256)
// PHI    | next byte is the high byte of an instruction word
// PLO    | next byte is the low byte; completes an instruction write
// PD     | next byte is a data byte; completes a data write
// CHK    | next byte is the checksum
// STAT   | one cycle reporting the frame result, input stalled
module prog_loader #(
  parameter int          ADDR_W   = 8,
  parameter int          INSTR_W  = 16,
  parameter int          DATA_W   = 8,
  parameter int          TIMEOUT  = 1024,
  parameter logic [7:0]  CMD_IMEM = 8'hA1,
  parameter logic [7:0]  CMD_DMEM = 8'hA2,
  parameter logic [7:0]  CMD_RUN  = 8'hA5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               dmem_we,
  output logic [ADDR_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  output logic               cpu_reset,
  output logic               busy,
  output logic               frame_ok,
  output logic               frame_err,
  output logic [1:0]         err_code
);

  localparam int CNT_W = 9;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LEN, S_PHI, S_PLO, S_PD, S_CHK, S_STAT
  } state_t;

  state_t              state_q, state_d;
  logic                is_imem_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [7:0]          hi_q;
  logic [7:0]          sum_q;
  logic [TMR_W-1:0]    tmr_q;

  logic accept;
  logic tmr_expired;
  logic start_frame, run_cmd, bad_cmd;
  logic ld_addr, ld_len, ld_hi, wr_imem, wr_dmem, chk_byte, abort_to;
  logic chk_match;

  assign rx_ready    = (state_q != S_STAT);
  assign busy        = (state_q != S_IDLE);
  assign accept      = rx_valid && rx_ready;
  assign chk_match   = (rx_data == sum_q);
  // The idle timer only runs inside a frame, and any accepted byte re-arms it.
  assign tmr_expired = (state_q != S_IDLE) && (state_q != S_STAT) &&
                       !accept && (tmr_q == '0);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode and per-byte datapath strobes.
  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    run_cmd     = 1'b0;
    bad_cmd     = 1'b0;
    ld_addr     = 1'b0;
    ld_len      = 1'b0;
    ld_hi       = 1'b0;
    wr_imem     = 1'b0;
    wr_dmem     = 1'b0;
    chk_byte    = 1'b0;
    abort_to    = 1'b0;
    if (tmr_expired) begin
      abort_to = 1'b1;
      state_d  = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          if (rx_data == CMD_IMEM || rx_data == CMD_DMEM) begin
            start_frame = 1'b1;
            state_d     = S_ADDR;
          end else if (rx_data == CMD_RUN) begin
            run_cmd = 1'b1;
          end else begin
            bad_cmd = 1'b1;
          end
        end
        S_ADDR: if (accept) begin
          ld_addr = 1'b1;
          state_d = S_LEN;
        end
        S_LEN: if (accept) begin
          ld_len  = 1'b1;
          state_d = is_imem_q ? S_PHI : S_PD;
        end
        S_PHI: if (accept) begin
          ld_hi   = 1'b1;
          state_d = S_PLO;
        end
        S_PLO: if (accept) begin
          wr_imem = 1'b1;
          state_d = (cnt_q == CNT_W'(1)) ? S_CHK : S_PHI;
        end
        S_PD: if (accept) begin
          wr_dmem = 1'b1;
          state_d = (cnt_q == CNT_W'(1)) ? S_CHK : S_PD;
        end
        S_CHK: if (accept) begin
          chk_byte = 1'b1;
          state_d  = S_STAT;
        end
        S_STAT: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Frame context: address, remaining count, high byte and running checksum.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      is_imem_q <= 1'b0;
      addr_q    <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      sum_q     <= '0;
    end else begin
      if (start_frame) begin
        is_imem_q <= (rx_data == CMD_IMEM);
        sum_q     <= '0;
      end
      if (ld_addr || ld_len || ld_hi || wr_imem || wr_dmem)
        sum_q <= sum_q + rx_data;
      if (ld_addr)
        addr_q <= ADDR_W'(rx_data);
      if (ld_len)
        cnt_q <= (rx_data == 8'd0) ? CNT_W'(256) : CNT_W'(rx_data);
      if (ld_hi)
        hi_q <= rx_data;
      if (wr_imem || wr_dmem) begin
        addr_q <= addr_q + ADDR_W'(1);
        cnt_q  <= cnt_q - CNT_W'(1);
      end
    end
  end

  // Registered memory write ports; strobes land the cycle after the completing byte.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else begin
      imem_we <= wr_imem;
      dmem_we <= wr_dmem;
      if (wr_imem) begin
        imem_addr  <= addr_q;
        imem_wdata <= INSTR_W'({hi_q, rx_data});
      end
      if (wr_dmem) begin
        dmem_addr  <= addr_q;
        dmem_wdata <= DATA_W'(rx_data);
      end
    end
  end

  // Frame status pulses, sticky error code and core hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'b00;
      cpu_reset <= 1'b1;
    end else begin
      frame_ok  <= run_cmd || (chk_byte && chk_match);
      frame_err <= bad_cmd || abort_to || (chk_byte && !chk_match);
      if (run_cmd || (chk_byte && chk_match)) err_code <= 2'b00;
      else if (bad_cmd)                       err_code <= 2'b01;
      else if (abort_to)                      err_code <= 2'b11;
      else if (chk_byte)                      err_code <= 2'b10;
      if (start_frame)  cpu_reset <= 1'b1;
      else if (run_cmd) cpu_reset <= 1'b0;
    end
  end

  // Down-counting idle timer; held loaded outside frames and on every byte.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      tmr_q <= TMR_W'(TIMEOUT - 1);
    else if (accept || state_q == S_IDLE || state_q == S_STAT)
      tmr_q <= TMR_W'(TIMEOUT - 1);
    else if (tmr_q != '0)
      tmr_q <= tmr_q - TMR_W'(1);
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: table of whole frames with expected results,
// plus hand sequences for RUN timing, timeout and reset mid-frame.
module tb_prog_loader;

  localparam int TIMEOUT = 1024;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        dmem_we;
  logic [7:0]  dmem_addr;
  logic [7:0]  dmem_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        frame_ok;
  logic        frame_err;
  logic [1:0]  err_code;

  prog_loader #(.TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .cpu_reset(cpu_reset), .busy(busy),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Event counters filled by the monitor, cleared per test.
  int iw_cnt, dw_cnt, ok_cnt, err_cnt, both_cnt;
  logic [1:0]  last_code;
  logic [7:0]  ia_first, ia_last, da_first, da_last;
  logic [15:0] id_first, id_last;
  logic [7:0]  dd_first, dd_last;

  typedef struct {
    logic [63:0] bytes;   // left-aligned, first byte in [63:56]
    int          n;
    logic        exp_ok;
    logic        exp_err;
    logic [1:0]  exp_code;
    logic        exp_cpu;
    int          exp_iw;
    int          exp_dw;
    logic [7:0]  wa0;
    logic [15:0] wd0;
    logic [7:0]  wa1;
    logic [15:0] wd1;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    iw_cnt = 0; dw_cnt = 0; ok_cnt = 0; err_cnt = 0;
    last_code = 2'b00;
  endtask

  // Sample outputs on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (imem_we && dmem_we) both_cnt++;
    if (imem_we) begin
      if (iw_cnt == 0) begin ia_first = imem_addr; id_first = imem_wdata; end
      ia_last = imem_addr; id_last = imem_wdata;
      iw_cnt++;
    end
    if (dmem_we) begin
      if (dw_cnt == 0) begin da_first = dmem_addr; dd_first = dmem_wdata; end
      da_last = dmem_addr; dd_last = dmem_wdata;
      dw_cnt++;
    end
    if (frame_ok) ok_cnt++;
    if (frame_err) begin
      err_cnt++;
      last_code = err_code;
    end
  end

  // Called at a falling edge; returns at the falling edge after the byte is taken.
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && t < 10) begin
      @(negedge clock);
      t++;
    end
    if (t >= 10) check("rx_ready stall bound", 32'(rx_ready), 32'd1);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic set_vec(input int i, input logic [63:0] b, input int n,
                         input logic ok, input logic err, input logic [1:0] code,
                         input logic cpu, input int iw, input int dw,
                         input logic [7:0] wa0, input logic [15:0] wd0,
                         input logic [7:0] wa1, input logic [15:0] wd1);
    vecs[i].bytes = b;  vecs[i].n = n;
    vecs[i].exp_ok = ok; vecs[i].exp_err = err; vecs[i].exp_code = code;
    vecs[i].exp_cpu = cpu; vecs[i].exp_iw = iw; vecs[i].exp_dw = dw;
    vecs[i].wa0 = wa0; vecs[i].wd0 = wd0; vecs[i].wa1 = wa1; vecs[i].wd1 = wd1;
  endtask

  task automatic apply_vec(input int i);
    vec_t v;
    logic [7:0] b;
    v = vecs[i];
    clear_counts();
    for (int k = 0; k < v.n; k++) begin
      b = v.bytes[63-8*k -: 8];
      send_byte(b);
    end
    rx_valid = 1'b0;
    // Frames with a checksum sit in STAT right after the last byte.
    check($sformatf("v%0d rx_ready after last byte", i), 32'(rx_ready), (v.n > 1) ? 32'd0 : 32'd1);
    repeat (4) @(negedge clock);
    check($sformatf("v%0d frame_ok count", i), 32'(ok_cnt), 32'(v.exp_ok));
    check($sformatf("v%0d frame_err count", i), 32'(err_cnt), 32'(v.exp_err));
    if (v.exp_err) check($sformatf("v%0d err_code", i), 32'(last_code), 32'(v.exp_code));
    check($sformatf("v%0d cpu_reset", i), 32'(cpu_reset), 32'(v.exp_cpu));
    check($sformatf("v%0d busy", i), 32'(busy), 32'd0);
    check($sformatf("v%0d imem_we pulses", i), 32'(iw_cnt), 32'(v.exp_iw));
    check($sformatf("v%0d dmem_we pulses", i), 32'(dw_cnt), 32'(v.exp_dw));
    if (v.exp_iw > 0) begin
      check($sformatf("v%0d imem first addr", i), 32'(ia_first), 32'(v.wa0));
      check($sformatf("v%0d imem first data", i), 32'(id_first), 32'(v.wd0));
      check($sformatf("v%0d imem last addr", i), 32'(ia_last), 32'(v.wa1));
      check($sformatf("v%0d imem last data", i), 32'(id_last), 32'(v.wd1));
    end
    if (v.exp_dw > 0) begin
      check($sformatf("v%0d dmem first addr", i), 32'(da_first), 32'(v.wa0));
      check($sformatf("v%0d dmem first data", i), 32'(dd_first), 32'(v.wd0));
      check($sformatf("v%0d dmem last addr", i), 32'(da_last), 32'(v.wa1));
      check($sformatf("v%0d dmem last data", i), 32'(dd_last), 32'(v.wd1));
    end
  endtask

  initial begin
    int cyc;
    int iw_before;
    //         bytes                          n  ok err code cpu iw dw  wa0    wd0       wa1    wd1
    set_vec(0, 64'hA1_00_02_01_26_10_32_6B,   8, 1, 0, 2'b00, 1, 2, 0, 8'h00, 16'h0126, 8'h01, 16'h1032);
    set_vec(1, 64'hA2_01_02_07_03_0D_00_00,   6, 1, 0, 2'b00, 1, 0, 2, 8'h01, 16'h0007, 8'h02, 16'h0003);
    set_vec(2, 64'hA5_00_00_00_00_00_00_00,   1, 1, 0, 2'b00, 0, 0, 0, 8'h00, 16'h0000, 8'h00, 16'h0000);
    set_vec(3, 64'hA1_FF_02_AA_BB_CC_DD_0F,   8, 1, 0, 2'b00, 1, 2, 0, 8'hFF, 16'hAABB, 8'h00, 16'hCCDD);
    set_vec(4, 64'hA2_05_01_44_00_00_00_00,   5, 0, 1, 2'b10, 1, 0, 1, 8'h05, 16'h0044, 8'h05, 16'h0044);
    set_vec(5, 64'h3C_00_00_00_00_00_00_00,   1, 0, 1, 2'b01, 1, 0, 0, 8'h00, 16'h0000, 8'h00, 16'h0000);
    set_vec(6, 64'hA2_03_01_5A_5E_00_00_00,   5, 1, 0, 2'b00, 1, 0, 1, 8'h03, 16'h005A, 8'h03, 16'h005A);

    both_cnt = 0;
    clear_counts();
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #3;
    check("reset rx_ready", 32'(rx_ready), 32'd1);
    check("reset cpu_reset", 32'(cpu_reset), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset imem_we", 32'(imem_we), 32'd0);
    check("reset dmem_we", 32'(dmem_we), 32'd0);
    check("reset frame_ok/err", 32'({frame_ok, frame_err}), 32'd0);
    check("reset err_code", 32'(err_code), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 6; i++) apply_vec(i);

    // RUN releases the core in the cycle right after the byte is taken.
    clear_counts();
    check("run cpu_reset before", 32'(cpu_reset), 32'd1);
    send_byte(8'hA5);
    rx_valid = 1'b0;
    check("run cpu_reset next cycle", 32'(cpu_reset), 32'd0);
    check("run frame_ok pulse", 32'(frame_ok), 32'd1);
    @(negedge clock);
    check("run frame_ok single cycle", 32'(frame_ok), 32'd0);

    // Timeout: command and address, then silence.
    clear_counts();
    send_byte(8'hA1);
    send_byte(8'h00);
    rx_valid = 1'b0;
    check("timeout busy during frame", 32'(busy), 32'd1);
    cyc = 0;
    while (!frame_err && cyc < TIMEOUT + 20) begin
      @(negedge clock);
      cyc++;
    end
    check("timeout frame_err seen", 32'(frame_err), 32'd1);
    check("timeout latency in window", 32'(cyc >= TIMEOUT - 1 && cyc <= TIMEOUT + 1), 32'd1);
    check("timeout err_code", 32'(err_code), 32'b11);
    check("timeout busy after", 32'(busy), 32'd0);
    check("timeout no writes", 32'(iw_cnt + dw_cnt), 32'd0);

    // Reset in the middle of an IMEM payload: one word written, then abort.
    repeat (2) @(negedge clock);
    clear_counts();
    send_byte(8'hA1);
    send_byte(8'h10);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    rx_valid = 1'b0;
    iw_before = iw_cnt;
    check("midreset word written before", 32'(iw_before), 32'd1);
    reset = 1'b1;
    #1;
    check("midreset imem_we", 32'(imem_we), 32'd0);
    check("midreset cpu_reset", 32'(cpu_reset), 32'd1);
    check("midreset rx_ready", 32'(rx_ready), 32'd1);
    check("midreset busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check("midreset no further writes", 32'(iw_cnt), 32'(iw_before));
    check("midreset still idle", 32'(busy), 32'd0);

    apply_vec(6);

    check("never both write strobes", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream program loader; the writing end of the core's instruction and data memories.
- Receives framed bytes on a valid/ready stream and writes 16-bit instructions into instruction memory or 8-bit bytes into data memory.
- Holds the core in reset while loading and releases it on a RUN command.
- Sits between the host/UART byte receiver and the memory write ports of the pipelined core.

Parameters:
- ADDR_W, 8, memory address width (256 locations).
- INSTR_W, 16, instruction word width; written as two bytes.
- DATA_W, 8, data memory word width.
- TIMEOUT, 1024, maximum idle cycles between bytes inside a frame before abort.
- CMD_IMEM, 8'hA1, command byte: instruction-memory write frame.
- CMD_DMEM, 8'hA2, command byte: data-memory write frame.
- CMD_RUN, 8'hA5, command byte: release core.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader can accept a byte.
- imem_we  out  1  instruction memory write strobe.
- imem_addr  out  ADDR_W  instruction memory write address.
- imem_wdata  out  INSTR_W  instruction word.
- dmem_we  out  1  data memory write strobe.
- dmem_addr  out  ADDR_W  data memory write address.
- dmem_wdata  out  DATA_W  data byte.
- cpu_reset  out  1  core hold; 1 = core held in reset.
- busy  out  1  frame in progress (state != IDLE).
- frame_ok  out  1  one-cycle pulse: frame completed with good checksum.
- frame_err  out  1  one-cycle pulse: frame aborted or bad.
- err_code  out  2  01 unknown cmd, 10 checksum mismatch, 11 timeout; holds until next frame_ok/frame_err.

Behaviour:
- Reset: clock and reset as already decided; reset is asynchronous, active-high, and clock is clock. On reset every output is 0 except rx_ready=1 and cpu_reset=1. The FSM returns to IDLE. Reset mid-frame discards the frame; no further writes occur.
- Byte transfer: a byte is accepted on a rising edge with rx_valid && rx_ready. rx_ready is 1 in every state except STAT.
- Frame format: CMD, ADDR, LEN, payload, CHK.
  - LEN = word count; 0 means 256.
  - IMEM payload: 2*N bytes per frame, high byte first.
  - DMEM payload: N bytes per frame.
  - CHK = (ADDR + LEN + all payload bytes) mod 256.
  - A RUN frame is the CMD byte only.
- FSM states: IDLE, ADDR, LEN, PHI, PLO, PD, CHK, STAT.
  - IDLE + CMD_IMEM/CMD_DMEM accepted: go to ADDR. cpu_reset=1 from the next cycle.
  - IDLE + CMD_RUN: cpu_reset=0 next cycle, frame_ok pulse, stay IDLE.
  - IDLE + any other byte: frame_err, err_code=01, stay IDLE.
  - ADDR: latch start address, go to LEN.
  - LEN: latch count (0 treated as 256). Go to PHI for an IMEM frame, PD for a DMEM frame.
  - PHI: latch high byte, go to PLO.
  - PLO: next cycle imem_we=1 for one cycle, with imem_wdata={hi,lo} and imem_addr=current address.
  - PD: next cycle dmem_we=1 for one cycle, with dmem_wdata=byte and dmem_addr=current address.
  - After each word write, the address increments modulo 256 (255 wraps to 0) and the count decrements. At count 0 go to CHK; otherwise return to PHI/PD.
  - CHK: compare received byte with the running sum, then go to STAT.
  - STAT (1 cycle, rx_ready=0): frame_ok on match; on mismatch frame_err with err_code=10. Then go to IDLE.
- Checksum error: words already written stay written. cpu_reset remains 1.
- Timeout: an idle counter resets on every accepted byte and counts while state is not IDLE or STAT. Reaching TIMEOUT gives frame_err, err_code=11, return to IDLE, no write.
- Write-strobe ordering: the write strobe is asserted in the cycle after the completing byte is accepted, and never both imem_we and dmem_we. If a timeout coincides with a pending write, the write completes first and the abort follows.
- Back-to-back bytes (rx_valid held high) are sustained at 1 byte/cycle except through STAT.

Test Plan:
- Reset, then stream A1 00 02 01 26 10 32 6B: imem[0]=16'h0126, imem[1]=16'h1032, two single-cycle imem_we pulses, frame_ok; cpu_reset stays 1.
- Stream A2 01 02 07 03 0D: dmem[1]=8'h07, dmem[2]=8'h03, frame_ok. Then A5: cpu_reset falls the next cycle.
- Stream A1 FF 02 AA BB CC DD with a correct CHK: writes land at addresses 8'hFF then 8'h00 (wrap).
- Stream A2 05 01 44 00 (bad CHK): dmem[5]=8'h44 written, frame_err, err_code=10, cpu_reset=1.
- Send byte 8'h3C in IDLE: frame_err, err_code=01, no writes. Send A1 00 then go idle for TIMEOUT cycles: frame_err, err_code=11, busy=0.
- Assert reset mid-payload of an IMEM frame: no further imem_we, cpu_reset=1, rx_ready=1, FSM IDLE. The next valid frame loads correctly.
